// File: rtl/para_pkg.sv
// Shared definitions for the layer-7 parameter streamer.
// Carries the interface defines (word width, mode and valid encodings),
// the parameter-group enum, the streamer FSM state enum and the
// per-group length helper used by the address generator.

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif
`ifndef LOAD_PARA
`define LOAD_PARA 1'b0
`endif
`ifndef DATAVALID
`define DATAVALID 1'b1
`endif
`ifndef RSTVALID
`define RSTVALID 1'b0
`endif

package para_pkg;

   localparam int unsigned PARA_GRP_W = 3;

   // Stream order of the parameter groups
   typedef enum logic [PARA_GRP_W-1:0] {
      PARA_GRP_RSIGN = 3'd0,
      PARA_GRP_BN_A  = 3'd1,
      PARA_GRP_BN_B  = 3'd2,
      PARA_GRP_BETA  = 3'd3,
      PARA_GRP_GAMMA = 3'd4,
      PARA_GRP_ZETA  = 3'd5
   } para_grp_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } para_state_e;

   // Number of words in a group: rsign is FM_DEPTH long, the rest CHANNEL_NUM
   function automatic int unsigned grp_len(input para_grp_e grp,
                                           input int unsigned fm_depth,
                                           input int unsigned channel_num);
      return (grp == PARA_GRP_RSIGN) ? fm_depth : channel_num;
   endfunction

endpackage

// File: rtl/para_addr_gen.sv
// Read counters for the parameter streamer.
// Holds the linear word index (rd_cnt), the current group (rd_grp) and the
// index within that group (rd_idx). adv steps all three with group wrap;
// clr returns them to zero. last_c flags that rd_cnt addresses the final word.
//   clk, rst_n : clock, async active-low reset
//   clr, adv   : clear (priority) / advance one word
//   rd_cnt     : linear word index
//   rd_grp     : group of the current word
//   last_c     : current word is word TOTAL-1 (combinational)

module para_addr_gen
   import para_pkg::*;
#(
   parameter int unsigned FM_DEPTH    = 128,
   parameter int unsigned CHANNEL_NUM = 256,
   parameter int unsigned TOTAL       = FM_DEPTH + 5*CHANNEL_NUM,
   parameter int unsigned CNT_W       = $clog2(TOTAL+1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] rd_cnt,
   output para_grp_e        rd_grp,
   output logic             last_c
);

   localparam int unsigned MAX_LEN = (FM_DEPTH > CHANNEL_NUM) ? FM_DEPTH : CHANNEL_NUM;
   localparam int unsigned IDX_W   = $clog2(MAX_LEN+1);

   logic [IDX_W-1:0] rd_idx;
   logic             grp_end_c;

   assign grp_end_c = (rd_idx == IDX_W'(grp_len(rd_grp, FM_DEPTH, CHANNEL_NUM) - 1));
   assign last_c    = (rd_cnt == CNT_W'(TOTAL - 1));

   // Counter update with group wrap at the end of each group
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt <= '0;
         rd_grp <= PARA_GRP_RSIGN;
         rd_idx <= '0;
      end else if (clr) begin
         rd_cnt <= '0;
         rd_grp <= PARA_GRP_RSIGN;
         rd_idx <= '0;
      end else if (adv) begin
         rd_cnt <= rd_cnt + CNT_W'(1);
         if (grp_end_c) begin
            rd_idx <= '0;
            rd_grp <= para_grp_e'(PARA_GRP_W'(rd_grp + 3'd1));
         end else begin
            rd_idx <= rd_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/para_streamer_layer7.sv
// Layer-7 parameter load transmitter.
// On start, reads all TOTAL parameter words from a 1-cycle-latency SRAM and
// streams them on para_out/data_e_para with the group tag on para_sel, while
// holding mode at LOAD_PARA; mode is released with the done pulse.
//   clk, rst_n   : clock, async active-low reset
//   start, pause : load request (IDLE only) / suppress new SRAM reads
//   mem_rd_en, mem_addr, mem_rdata : SRAM read port
//   mode, data_e_para, para_out, para_sel : loader interface
//   busy, done   : load in progress / one-cycle completion pulse

module para_streamer_layer7
   import para_pkg::*;
#(
   parameter int unsigned FM_DEPTH    = 128,
   parameter int unsigned CHANNEL_NUM = 256,
   parameter int unsigned ADDR_WIDTH  = 11,
   parameter int unsigned BASE_ADDR   = 0
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          pause,
   output logic                          mem_rd_en,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic signed [`PARA_WIDTH-1:0] mem_rdata,
   output logic                          mode,
   output logic                          data_e_para,
   output logic signed [`PARA_WIDTH-1:0] para_out,
   output logic [2:0]                    para_sel,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned TOTAL     = FM_DEPTH + 5*CHANNEL_NUM;
   localparam int unsigned CNT_W     = $clog2(TOTAL+1);
   localparam logic        MODE_CALC = ~`LOAD_PARA;

   para_state_e             state, state_d;
   logic                    mem_rd_en_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_d;
   logic                    busy_d, done_d, mode_d;
   para_grp_e               grp_q1, grp_q1_d, grp_q2;
   logic                    v1;
   logic                    adv, clr;
   logic [CNT_W-1:0]        rd_cnt;
   para_grp_e               rd_grp;
   logic                    last_c;

   para_addr_gen #(
      .FM_DEPTH    (FM_DEPTH),
      .CHANNEL_NUM (CHANNEL_NUM),
      .TOTAL       (TOTAL),
      .CNT_W       (CNT_W)
   ) u_addr_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .adv    (adv),
      .rd_cnt (rd_cnt),
      .rd_grp (rd_grp),
      .last_c (last_c)
   );

   // FSM state and registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mode      <= `LOAD_PARA;
         grp_q1    <= PARA_GRP_RSIGN;
      end else begin
         state     <= state_d;
         mem_rd_en <= mem_rd_en_d;
         mem_addr  <= mem_addr_d;
         busy      <= busy_d;
         done      <= done_d;
         mode      <= mode_d;
         grp_q1    <= grp_q1_d;
      end
   end

   // Next state; the accepting edge already issues word 0 so data starts early
   always_comb begin
      state_d     = state;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr;
      busy_d      = busy;
      done_d      = 1'b0;
      mode_d      = mode;
      grp_q1_d    = grp_q1;
      adv         = 1'b0;
      clr         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_d = READ;
               busy_d  = 1'b1;
               mode_d  = `LOAD_PARA;
               if (!pause) begin
                  mem_rd_en_d = 1'b1;
                  mem_addr_d  = ADDR_WIDTH'(BASE_ADDR + rd_cnt);
                  grp_q1_d    = rd_grp;
                  adv         = 1'b1;
               end
            end
         end
         READ: begin
            if (!pause) begin
               mem_rd_en_d = 1'b1;
               mem_addr_d  = ADDR_WIDTH'(BASE_ADDR + rd_cnt);
               grp_q1_d    = rd_grp;
               // Counters return to zero after the last issue for the next load
               if (last_c) begin
                  clr     = 1'b1;
                  state_d = DRAIN;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         DRAIN: begin
            // Final beat on the bus and nothing left in flight
            if (!mem_rd_en && !v1 && (data_e_para == `DATAVALID)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               mode_d  = MODE_CALC;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read-data pipeline: rd_en -> v1 (rdata valid) -> data_e_para
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1          <= 1'b0;
         grp_q2      <= PARA_GRP_RSIGN;
         data_e_para <= 1'b0;
         para_out    <= '0;
         para_sel    <= '0;
      end else begin
         v1          <= mem_rd_en;
         grp_q2      <= grp_q1;
         data_e_para <= v1 ? `DATAVALID : ~`DATAVALID;
         if (v1) begin
            para_out <= mem_rdata;
            para_sel <= grp_q2;
         end
      end
   end

endmodule
